// File: rtl/vram_scan_scheduler.sv
// Shares the single VRAM read port between Avalon CPU reads and the per-scanline
// header/score/board-row prefetch, committing prefetched words at line start.
module vram_scan_scheduler #(
  parameter int ADDR_W        = 11,
  parameter int FETCH_X       = 640,
  parameter int V_TOTAL       = 525,
  parameter int HDR_ADDR      = 0,
  parameter int SCORE_ADDR    = 1,
  parameter int BOARD_BASE    = 2,
  parameter int BOARD_TOP_ROW = 5,
  parameter int BOARD_ROWS    = 20
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic [9:0]        DRAWX,
  input  logic [9:0]        DRAWY,
  input  logic              AVL_CS,
  input  logic              AVL_READ,
  input  logic [ADDR_W-1:0] AVL_ADDR,
  output logic              AVL_WAITREQUEST,
  output logic [ADDR_W-1:0] RAM_RDADDR,
  input  logic [31:0]       RAM_Q,
  output logic [31:0]       HDR_WORD,
  output logic [31:0]       SCORE_WORD,
  output logic [31:0]       ROW_WORD,
  output logic              ROW_VALID,
  output logic              FETCH_MISS
);

  localparam logic [9:0]        FETCH_X_C = 10'(FETCH_X);
  localparam logic [9:0]        V_LAST    = 10'(V_TOTAL - 1);
  localparam logic [ADDR_W-1:0] HDR_A     = ADDR_W'(HDR_ADDR);
  localparam logic [ADDR_W-1:0] SCORE_A   = ADDR_W'(SCORE_ADDR);
  localparam logic [ADDR_W-1:0] BASE_A    = ADDR_W'(BOARD_BASE);
  localparam logic [ADDR_W-1:0] TOP_A     = ADDR_W'(BOARD_TOP_ROW);
  localparam logic [5:0]        ROW_FIRST = 6'(BOARD_TOP_ROW);
  localparam logic [5:0]        ROW_LAST  = 6'(BOARD_TOP_ROW + BOARD_ROWS - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    CPU_ISSUE = 3'd1,
    CPU_DATA  = 3'd2,
    F_HDR     = 3'd3,
    F_SCORE   = 3'd4,
    F_ROW     = 3'd5,
    F_LAST    = 3'd6
  } state_t;

  state_t              state_r, next_state_s;
  logic [9:0]          prev_drawx_r;
  logic                fetch_trig_s, commit_trig_s;
  logic [9:0]          ny_s;
  logic [5:0]          nrow_s;
  logic                in_board_s, in_board_r;
  logic [ADDR_W-1:0]   row_addr_s, row_addr_r;
  logic                fetch_pending_r, fetch_done_r;
  logic [31:0]         hdr_stg_r, score_stg_r, row_stg_r;
  logic                cap_hdr_s, cap_score_s, cap_row_s, last_s, wait_s;
  logic [ADDR_W-1:0]   next_addr_s, ram_rdaddr_r;
  logic [31:0]         hdr_word_r, score_word_r, row_word_r;
  logic                row_valid_r, fetch_miss_r;

  assign fetch_trig_s  = (DRAWX == FETCH_X_C) && (prev_drawx_r != FETCH_X_C);
  assign commit_trig_s = (DRAWX == 10'd0) && (prev_drawx_r != 10'd0);

  // Which line comes next and where its board row lives in VRAM.
  always_comb begin
    ny_s       = (DRAWY == V_LAST) ? 10'd0 : DRAWY + 10'd1;
    nrow_s     = 6'(ny_s >> 4);
    in_board_s = (nrow_s >= ROW_FIRST) && (nrow_s <= ROW_LAST);
    row_addr_s = BASE_A + ADDR_W'(nrow_s) - TOP_A;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_r      <= IDLE;
      ram_rdaddr_r <= HDR_A;
    end else begin
      state_r      <= next_state_s;
      ram_rdaddr_r <= next_addr_s;
    end
  end

  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (fetch_pending_r)          next_state_s = F_HDR;
        else if (AVL_CS && AVL_READ)  next_state_s = CPU_ISSUE;
        else                          next_state_s = IDLE;
      end
      CPU_ISSUE: next_state_s = CPU_DATA;
      CPU_DATA:  next_state_s = IDLE;
      F_HDR:     next_state_s = F_SCORE;
      F_SCORE:   next_state_s = in_board_r ? F_ROW : F_LAST;
      F_ROW:     next_state_s = F_LAST;
      F_LAST:    next_state_s = IDLE;
      default:   next_state_s = IDLE;
    endcase
  end

  // The read address is registered from the upcoming state, so it is presented
  // throughout the state that owns it and RAM_Q lands in the following state.
  always_comb begin
    wait_s      = AVL_CS & AVL_READ & (state_r != CPU_DATA);
    cap_hdr_s   = 1'b0;
    cap_score_s = 1'b0;
    cap_row_s   = 1'b0;
    last_s      = 1'b0;
    case (state_r)
      F_SCORE: cap_hdr_s   = 1'b1;
      F_ROW:   cap_score_s = 1'b1;
      F_LAST: begin
        last_s = 1'b1;
        if (in_board_r) cap_row_s   = 1'b1;
        else            cap_score_s = 1'b1;
      end
      default: last_s = 1'b0;
    endcase
    case (next_state_s)
      CPU_ISSUE: next_addr_s = AVL_ADDR;
      F_HDR:     next_addr_s = HDR_A;
      F_SCORE:   next_addr_s = SCORE_A;
      F_ROW:     next_addr_s = row_addr_r;
      default:   next_addr_s = HDR_A;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      prev_drawx_r    <= 10'd0;
      in_board_r      <= 1'b0;
      row_addr_r      <= '0;
      fetch_pending_r <= 1'b0;
      fetch_done_r    <= 1'b0;
      hdr_stg_r       <= 32'd0;
      score_stg_r     <= 32'd0;
      row_stg_r       <= 32'd0;
    end else begin
      prev_drawx_r <= DRAWX;
      if (fetch_trig_s) begin
        in_board_r <= in_board_s;
        row_addr_r <= row_addr_s;
      end
      if (fetch_trig_s)      fetch_pending_r <= 1'b1;
      else if (last_s)       fetch_pending_r <= 1'b0;
      if (last_s)                             fetch_done_r <= 1'b1;
      else if (commit_trig_s && fetch_done_r) fetch_done_r <= 1'b0;
      if (cap_hdr_s)   hdr_stg_r   <= RAM_Q;
      if (cap_score_s) score_stg_r <= RAM_Q;
      if (cap_row_s)   row_stg_r   <= RAM_Q;
    end
  end

  // A commit with no completed prefetch keeps the old line and latches the miss.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      hdr_word_r   <= 32'd0;
      score_word_r <= 32'd0;
      row_word_r   <= 32'd0;
      row_valid_r  <= 1'b0;
      fetch_miss_r <= 1'b0;
    end else if (commit_trig_s) begin
      if (fetch_done_r) begin
        hdr_word_r   <= hdr_stg_r;
        score_word_r <= score_stg_r;
        row_word_r   <= row_stg_r;
        row_valid_r  <= in_board_r;
      end else begin
        fetch_miss_r <= 1'b1;
      end
    end
  end

  assign AVL_WAITREQUEST = wait_s;
  assign RAM_RDADDR      = ram_rdaddr_r;
  assign HDR_WORD        = hdr_word_r;
  assign SCORE_WORD      = score_word_r;
  assign ROW_WORD        = row_word_r;
  assign ROW_VALID       = row_valid_r;
  assign FETCH_MISS      = fetch_miss_r;

endmodule

// File: tb/tb_vram_scan_scheduler.sv
// Bench for vram_scan_scheduler: table of scanlines with optional CPU-read
// collisions, scoreboard queues for committed words and CPU read results.
module tb_vram_scan_scheduler;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [9:0]  DRAWX, DRAWY;
  logic        AVL_CS, AVL_READ;
  logic [10:0] AVL_ADDR;
  logic        AVL_WAITREQUEST;
  logic [10:0] RAM_RDADDR;
  logic [31:0] RAM_Q;
  logic [31:0] HDR_WORD, SCORE_WORD, ROW_WORD;
  logic        ROW_VALID, FETCH_MISS;

  vram_scan_scheduler dut (
    .CLK(CLK), .RESET(RESET), .DRAWX(DRAWX), .DRAWY(DRAWY),
    .AVL_CS(AVL_CS), .AVL_READ(AVL_READ), .AVL_ADDR(AVL_ADDR),
    .AVL_WAITREQUEST(AVL_WAITREQUEST), .RAM_RDADDR(RAM_RDADDR), .RAM_Q(RAM_Q),
    .HDR_WORD(HDR_WORD), .SCORE_WORD(SCORE_WORD), .ROW_WORD(ROW_WORD),
    .ROW_VALID(ROW_VALID), .FETCH_MISS(FETCH_MISS)
  );

  always #10 CLK = ~CLK;

  logic [31:0] vram [0:2047];
  always @(posedge CLK) RAM_Q <= vram[RAM_RDADDR];

  typedef struct {
    logic [9:0]  y;
    bit          skip;
    int          mode;   // 0 none, 1 CPU read one cycle before fetch_trig, 2 CPU read during F_SCORE
    logic [31:0] hdr;
    logic [31:0] score;
  } line_t;

  typedef struct {
    logic [31:0] hdr, score, row;
    logic        valid, miss;
  } out_t;

  line_t       lines [9];
  out_t        exp_q [$];
  logic [31:0] cpu_q [$];
  int          lat_q [$];
  out_t        prev_m;
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, expv);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic run_line(input line_t e);
    logic [9:0]  ny;
    logic [5:0]  nrow;
    bit          ib;
    logic [10:0] raddr, addr_after;
    out_t        ex, got;
    int          cpu_start, first_c;
    bit          cpu_active;
    ny         = (e.y == 10'd524) ? 10'd0 : e.y + 10'd1;
    nrow       = ny[9:4];
    ib         = (nrow >= 6'd5) && (nrow <= 6'd24);
    raddr      = 11'd2 + {5'd0, nrow} - 11'd5;
    vram[0]    = e.hdr;
    vram[1]    = e.score;
    DRAWY      = e.y;
    ex         = prev_m;
    if (e.skip) begin
      ex.miss = 1'b1;
    end else begin
      ex.hdr   = e.hdr;
      ex.score = e.score;
      ex.valid = ib;
      if (ib) ex.row = vram[raddr];
    end
    exp_q.push_back(ex);
    cpu_start  = (e.mode == 1) ? 1 : (e.mode == 2) ? 5 : -1;
    first_c    = -1;
    addr_after = 11'd0;
    cpu_active = 1'b0;
    for (int c = 0; c < 24; c++) begin
      if (first_c < 0 && RAM_RDADDR == 11'd1) first_c = c;
      if (first_c >= 0 && c == first_c + 1) addr_after = RAM_RDADDR;
      if (cpu_active && !AVL_WAITREQUEST) begin
        check("cpu_data", RAM_Q, cpu_q.pop_front());
        check("cpu_latency", 32'(c - cpu_start), 32'(lat_q.pop_front()));
        AVL_CS = 1'b0; AVL_READ = 1'b0; cpu_active = 1'b0;
      end
      if (c == cpu_start) begin
        AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 11'h15;
        cpu_q.push_back(vram[11'h15]);
        lat_q.push_back((e.mode == 1) ? 2 : (ib ? 5 : 4));
        cpu_active = 1'b1;
      end
      if (e.skip) DRAWX = (c < 2) ? 10'd600 : 10'd639;
      else        DRAWX = (c < 2) ? 10'd600 : ((c < 4) ? 10'd640 : 10'd641);
      step();
    end
    if (cpu_active) begin
      checks++; errors++;
      $display("FAIL cpu_timeout line y=%0d waitrequest still high", e.y);
      AVL_CS = 1'b0; AVL_READ = 1'b0;
      cpu_q.delete(); lat_q.delete();
    end
    if (e.skip) begin
      check("skip_no_fetch", 32'(first_c), 32'hFFFF_FFFF);
    end else begin
      check("score_addr_cycle", 32'(first_c), (e.mode == 1) ? 32'd6 : 32'd5);
      check("addr_after_score", {21'd0, addr_after}, ib ? {21'd0, raddr} : 32'd0);
    end
    check("hold_hdr", HDR_WORD, prev_m.hdr);
    check("hold_row", ROW_WORD, prev_m.row);
    check("hold_valid", {31'd0, ROW_VALID}, {31'd0, prev_m.valid});
    DRAWY = ny;
    DRAWX = 10'd0;
    step();
    got = exp_q.pop_front();
    check("hdr_word", HDR_WORD, got.hdr);
    check("score_word", SCORE_WORD, got.score);
    check("row_word", ROW_WORD, got.row);
    check("row_valid", {31'd0, ROW_VALID}, {31'd0, got.valid});
    check("fetch_miss", {31'd0, FETCH_MISS}, {31'd0, got.miss});
    prev_m = got;
    step();
    DRAWX = 10'd1;
    step();
    step();
  endtask

  initial begin
    int n;
    for (int i = 0; i < 2048; i++) vram[i] = 32'hB000_0000 | i;
    vram[11'h15] = 32'hDEAD_0015;
    lines[0] = '{10'd100, 1'b0, 0, 32'h0003_0012, 32'h0000_4520};
    lines[1] = '{10'd524, 1'b0, 0, 32'h0004_0013, 32'h0000_4600};
    lines[2] = '{10'd79,  1'b0, 1, 32'h0005_0014, 32'h0000_4700};
    lines[3] = '{10'd398, 1'b0, 2, 32'h0006_0015, 32'h0000_4800};
    lines[4] = '{10'd399, 1'b0, 0, 32'h0007_0016, 32'h0000_4900};
    lines[5] = '{10'd78,  1'b0, 2, 32'h0008_0017, 32'h0000_4A00};
    lines[6] = '{10'd200, 1'b1, 0, 32'h0009_0018, 32'h0000_4B00};
    lines[7] = '{10'd300, 1'b0, 0, 32'h000A_0019, 32'h0000_4C00};
    lines[8] = '{10'd350, 1'b0, 1, 32'h000B_001A, 32'h0000_4D00};
    prev_m = '{32'd0, 32'd0, 32'd0, 1'b0, 1'b0};

    RESET = 1'b1; DRAWX = 10'd0; DRAWY = 10'd0;
    AVL_CS = 1'b1; AVL_READ = 1'b1; AVL_ADDR = 11'h15;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_waitreq", {31'd0, AVL_WAITREQUEST}, 32'd1);
    end
    check("reset_hdr", HDR_WORD, 32'd0);
    check("reset_score", SCORE_WORD, 32'd0);
    check("reset_row", ROW_WORD, 32'd0);
    check("reset_valid", {31'd0, ROW_VALID}, 32'd0);
    check("reset_miss", {31'd0, FETCH_MISS}, 32'd0);
    check("reset_rdaddr", {21'd0, RAM_RDADDR}, 32'd0);
    RESET = 1'b0;
    n = 0;
    for (int i = 1; i <= 10; i++) begin
      step();
      if (!AVL_WAITREQUEST) begin n = i; break; end
    end
    check("post_reset_read_latency", 32'(n), 32'd2);
    check("post_reset_read_data", RAM_Q, 32'hDEAD_0015);
    AVL_CS = 1'b0; AVL_READ = 1'b0;
    step();

    for (int i = 0; i < 9; i++) run_line(lines[i]);

    AVL_CS = 1'b1; AVL_READ = 1'b1;
    step();
    RESET = 1'b1;
    step();
    check("abort_waitreq", {31'd0, AVL_WAITREQUEST}, 32'd1);
    check("abort_miss_cleared", {31'd0, FETCH_MISS}, 32'd0);
    check("abort_hdr_cleared", HDR_WORD, 32'd0);
    check("abort_valid_cleared", {31'd0, ROW_VALID}, 32'd0);
    RESET = 1'b0; AVL_CS = 1'b0; AVL_READ = 1'b0;
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
